// File: rtl/exec_muldiv.sv
// ============================================================================
// exec_muldiv : multi-cycle multiply / restoring divide execution unit
// Signed operation is enabled by defining EXEC_MULDIV_SIGNED_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module exec_muldiv #(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    input  logic [1:0]       op,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       rd_in,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data,
    output logic [4:0]       rd_out
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] C_MUL_LAST = CW'(MUL_LATENCY - 1);
    localparam logic [CW-1:0] C_DIV_LAST = CW'(WIDTH);

`ifdef EXEC_MULDIV_SIGNED_EN
    localparam logic C_SIGNED_EN = 1'b1;
`else
    localparam logic C_SIGNED_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL     = 2'd1,
        DIV_RUN = 2'd2,
        FIN     = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_op_lo;
    logic             r_sgn;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [4:0]       r_rd;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;

    logic               w_signed;
    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_mul_res;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_div_zero;
    logic               w_ovf;
    logic               w_fast;
    logic [WIDTH-1:0]   w_fast_res;
    logic [WIDTH:0]     w_rem_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;
    logic               w_neg_q;
    logic               w_neg_r;
    logic [WIDTH-1:0]   w_div_res;

    assign w_signed = r_sgn & C_SIGNED_EN;

    // Sign-extending to 2*WIDTH makes one multiplier serve signed and unsigned
    assign w_a_ext   = {{WIDTH{w_signed & r_a[WIDTH-1]}}, r_a};
    assign w_b_ext   = {{WIDTH{w_signed & r_b[WIDTH-1]}}, r_b};
    assign w_prod    = w_a_ext * w_b_ext;
    assign w_mul_res = r_op_lo ? w_prod[2*WIDTH-1:WIDTH] : w_prod[WIDTH-1:0];

    assign w_mag_a = (w_signed & r_a[WIDTH-1]) ? (~r_a + 1'b1) : r_a;
    assign w_mag_b = (w_signed & r_b[WIDTH-1]) ? (~r_b + 1'b1) : r_b;

    assign w_div_zero = (r_b == '0);
    assign w_ovf      = w_signed && (r_a == {1'b1, {(WIDTH-1){1'b0}}}) && (r_b == '1);
    assign w_fast     = w_div_zero | w_ovf;
    always_comb begin
        w_fast_res = '0;
        if (w_div_zero) w_fast_res = r_op_lo ? r_a : '1;
        else            w_fast_res = r_op_lo ? '0  : r_a;
    end

    // One restoring step: shift the next dividend bit in, subtract if it fits
    assign w_rem_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff      = w_rem_shift - {1'b0, r_dvs};
    assign w_ge        = ~w_diff[WIDTH];
    assign w_rem_nxt   = w_ge ? w_diff[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
    assign w_quo_nxt   = {r_quo[WIDTH-2:0], w_ge};

    assign w_neg_q   = w_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
    assign w_neg_r   = w_signed & r_a[WIDTH-1];
    assign w_div_res = r_op_lo ? (w_neg_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt)
                               : (w_neg_q ? (~w_quo_nxt + 1'b1) : w_quo_nxt);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (enable) w_next = op[1] ? DIV_RUN : MUL;
            MUL:     if (r_cnt == C_MUL_LAST) w_next = FIN;
            DIV_RUN: if ((r_cnt == '0 && w_fast) || r_cnt == C_DIV_LAST) w_next = FIN;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (flush) w_next = IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_op_lo <= 1'b0;
            r_sgn   <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_rd    <= '0;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            data    <= '0;
            rd_out  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (enable && !flush) begin
                        r_op_lo <= op[0];
                        r_sgn   <= sgn;
                        r_a     <= a;
                        r_b     <= b;
                        r_rd    <= rd_in;
                    end
                end
                MUL: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_MUL_LAST && !flush) begin
                        data   <= w_mul_res;
                        rd_out <= r_rd;
                    end
                end
                DIV_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == '0) begin
                        r_rem <= '0;
                        r_quo <= w_mag_a;
                        r_dvs <= w_mag_b;
                        if (w_fast && !flush) begin
                            data   <= w_fast_res;
                            rd_out <= r_rd;
                        end
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        if (r_cnt == C_DIV_LAST && !flush) begin
                            data   <= w_div_res;
                            rd_out <= r_rd;
                        end
                    end
                end
                default: r_cnt <= '0;
            endcase
            if (flush) r_cnt <= '0;
        end
    end

    assign busy = (r_state != IDLE);
    assign done = (r_state == FIN);

endmodule

`default_nettype wire

// File: tb/tb_exec_muldiv.sv
// ============================================================================
// tb_exec_muldiv : directed self-checking bench for exec_muldiv (WIDTH=32)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_exec_muldiv;

`ifdef EXEC_MULDIV_SIGNED_EN
    localparam bit SIGNED = 1'b1;
`else
    localparam bit SIGNED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  op = 2'd0;
    logic        sgn = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  rd_in = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] data;
    logic [4:0]  rd_out;

    int n_checks = 0;
    int n_pass   = 0;

    exec_muldiv #(.WIDTH(32), .MUL_LATENCY(2)) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .op(op), .sgn(sgn),
        .a(a), .b(b), .rd_in(rd_in), .flush(flush),
        .busy(busy), .done(done), .data(data), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Start one op at the next edge (edge N), then count edges until done is seen
    task automatic run(input logic [1:0] o, input logic s, input logic [31:0] x,
                       input logic [31:0] y, input logic [4:0] tag,
                       output int lat, output int busy_cnt, output logic [31:0] res);
        @(negedge clk);
        op = o; sgn = s; a = x; b = y; rd_in = tag; enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        res = data;
    endtask

    task automatic op_check(input string name, input logic [1:0] o, input logic s,
                            input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] exp_res, input int exp_lat);
        int lat, bc;
        logic [31:0] res;
        logic [4:0] tag;
        tag = 5'($urandom_range(1, 31));
        run(o, s, x, y, tag, lat, bc, res);
        check({name, "_data"}, res, exp_res);
        check({name, "_lat"}, lat, exp_lat);
        check({name, "_tag"}, rd_out, tag);
        @(posedge clk); #1;
        check({name, "_one_pulse"}, {busy, done}, 2'b00);
    endtask

    initial begin
        int lat, bc, cyc;
        logic [31:0] res, held;
        logic saw_done;

        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_data", data, 32'h0);
        check("rst_rdout", rd_out, 5'h0);
        #22 rstn = 1'b1;

        // First start right after reset release
        op_check("mul_lo", 2'b00, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 2);
        op_check("mulh", 2'b01, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 2);
        op_check("mul_neg", 2'b00, 1'b1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 2);
        op_check("mulh_neg", 2'b01, 1'b1, 32'hFFFF_FFFD, 32'd5,
                 SIGNED ? 32'hFFFF_FFFF : 32'h0000_0004, 2);

        run(2'b10, 1'b0, 32'd100, 32'd7, 5'd9, lat, bc, res);
        check("div100_data", res, 32'd14);
        check("div100_lat", lat, 33);
        check("div100_busy", bc, 33);
        @(posedge clk); #1;
        op_check("rem100", 2'b11, 1'b0, 32'd100, 32'd7, 32'd2, 33);

        op_check("div_m7", 2'b10, 1'b1, 32'hFFFF_FFF9, 32'd2,
                 SIGNED ? 32'hFFFF_FFFD : 32'h7FFF_FFFC, 33);
        op_check("rem_m7", 2'b11, 1'b1, 32'hFFFF_FFF9, 32'd2,
                 SIGNED ? 32'hFFFF_FFFF : 32'h0000_0001, 33);
        op_check("div_7_m2", 2'b10, 1'b1, 32'd7, 32'hFFFF_FFFE,
                 SIGNED ? 32'hFFFF_FFFD : 32'h0, 33);
        op_check("rem_7_m2", 2'b11, 1'b1, 32'd7, 32'hFFFF_FFFE,
                 SIGNED ? 32'h1 : 32'h7, 33);
        op_check("div_big", 2'b10, 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 33);
        op_check("rem_big", 2'b11, 1'b0, 32'hFFFF_FFFF, 32'h10, 32'hF, 33);
        op_check("div_by0", 2'b10, 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        op_check("rem_by0", 2'b11, 1'b0, 32'd5, 32'd0, 32'd5, 1);
        op_check("div_ovf", 2'b10, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
                 SIGNED ? 32'h8000_0000 : 32'h0, SIGNED ? 1 : 33);
        op_check("rem_ovf", 2'b11, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
                 SIGNED ? 32'h0 : 32'h8000_0000, SIGNED ? 1 : 33);

        // Flush at edge N+10 together with a new enable
        held = data;
        @(negedge clk);
        op = 2'b10; sgn = 1'b0; a = 32'd1000; b = 32'd3; rd_in = 5'd4; enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1; enable = 1'b1; op = 2'b00;
        @(posedge clk); #1;
        flush = 1'b0; enable = 1'b0;
        check("flush_busy", busy, 1'b0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        check("flush_quiet", saw_done, 1'b0);
        check("flush_data", data, held);

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        op = 2'b10; a = 32'd1000; b = 32'd3; rd_in = 5'd6; enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check("arst_state", {busy, done, rd_out}, 7'h0);
        check("arst_data", data, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        check("arst_no_done", saw_done, 1'b0);

        // Back-to-back: enable held high straight through the done pulse
        @(negedge clk);
        op = 2'b00; sgn = 1'b0; a = 32'd6; b = 32'd7; rd_in = 5'd11; enable = 1'b1;
        @(posedge clk); #1;
        cyc = 0;
        while (!done && cyc < 20) begin @(posedge clk); #1; cyc++; end
        check("b2b_first_lat", cyc, 2);
        check("b2b_first_data", data, 32'd42);
        b = 32'd9; rd_in = 5'd12;
        @(posedge clk); #1;
        check("b2b_gap", {busy, done}, 2'b00);
        @(posedge clk); #1;
        check("b2b_restart", busy, 1'b1);
        enable = 1'b0;
        cyc = 0;
        while (!done && cyc < 20) begin @(posedge clk); #1; cyc++; end
        check("b2b_second_lat", cyc, 2);
        check("b2b_second_data", data, 32'd54);
        check("b2b_second_tag", rd_out, 5'd12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
